// File: rtl/vu_vxu_bptr_tracker_pkg.sv
// Shared sizing, FSM encoding and config legality check for the VXU bank-pointer tracker.
// Every width is derived from NBANK_MAX, MIN_BCNT and MAX_INCR.
package vu_vxu_bptr_tracker_pkg;

  localparam int NBANK_MAX  = 8;
  localparam int LGBANK     = $clog2(NBANK_MAX);
  localparam int BCNT_W     = $clog2(NBANK_MAX + 1);
  localparam int MIN_BCNT   = 3;
  localparam int MAX_INCR   = 17;
  localparam int INCR_W     = $clog2(MAX_INCR + 1);
  localparam int NCHAN      = 4;
  localparam int RESET_BCNT = 8;
  localparam int SUM_W      = $clog2(NBANK_MAX + MAX_INCR);
  // Largest sum is NBANK_MAX-1+MAX_INCR; each step removes at least MIN_BCNT.
  localparam int NSUB       = (NBANK_MAX - 1 + MAX_INCR + MIN_BCNT - 1) / MIN_BCNT;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_CFG = 1'b1
  } state_t;

  function automatic logic bcnt_legal(input logic [BCNT_W-1:0] b);
    return (b >= BCNT_W'(MIN_BCNT)) && (b <= BCNT_W'(NBANK_MAX));
  endfunction

endpackage

// File: rtl/vu_vxu_bptr_mod.sv
// Combinational (base + incr) mod bcnt using a fixed chain of conditional subtractions.
// Latency 0. There is no handshake: the result is pure logic.
module vu_vxu_bptr_mod
  import vu_vxu_bptr_tracker_pkg::*;
(
  input  logic [LGBANK-1:0] base,
  input  logic [INCR_W-1:0] incr,
  input  logic [BCNT_W-1:0] bcnt,
  output logic [LGBANK-1:0] res,
  output logic              wrap
);

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] div;
  logic [SUM_W-1:0] rem;

  always_comb begin
    sum = SUM_W'(base) + SUM_W'(incr);
    div = SUM_W'(bcnt);
    rem = sum;
    for (int k = 0; k < NSUB; k++) begin
      if (rem >= div) rem = rem - div;
    end
    res  = LGBANK'(rem);
    wrap = (sum >= div);
  end

endmodule

// File: rtl/vu_vxu_bptr_tracker.sv
// Per-channel bank pointers advanced modulo a runtime bank count, with seeding and reconfiguration.
// Outputs are registered with a latency of 1. A config offer stalls every advance in that cycle, and the CFG state stalls them for one cycle.
module vu_vxu_bptr_tracker
  import vu_vxu_bptr_tracker_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [BCNT_W-1:0]        cfg_bcnt,
  output logic                     cfg_err,
  output logic [BCNT_W-1:0]        bcnt,
  input  logic [NCHAN-1:0]         adv_valid,
  output logic                     adv_ready,
  input  logic [NCHAN*INCR_W-1:0]  adv_incr,
  input  logic [NCHAN-1:0]         set_valid,
  input  logic [NCHAN*LGBANK-1:0]  set_ptr,
  output logic [NCHAN*LGBANK-1:0]  ptr,
  output logic [NCHAN-1:0]         wrap
);

  state_t                         state_q, state_d;
  logic [BCNT_W-1:0]              bcnt_q, bcnt_d;
  logic [NCHAN-1:0][LGBANK-1:0]   ptr_q, ptr_d;
  logic [NCHAN-1:0]               wrap_q, wrap_d;
  logic                           cfg_err_q, cfg_err_d;

  logic [NCHAN-1:0][LGBANK-1:0]   adv_res;
  logic [NCHAN-1:0]               adv_wrap;
  logic [NCHAN-1:0][LGBANK-1:0]   seed_res;
  logic [NCHAN-1:0]               seed_wrap_unused;

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    vu_vxu_bptr_mod u_adv (
      .base (ptr_q[c]),
      .incr (adv_incr[c*INCR_W +: INCR_W]),
      .bcnt (bcnt_q),
      .res  (adv_res[c]),
      .wrap (adv_wrap[c])
    );

    // A seed is the same reduction with a zero increment.
    vu_vxu_bptr_mod u_seed (
      .base (set_ptr[c*LGBANK +: LGBANK]),
      .incr (INCR_W'(0)),
      .bcnt (bcnt_q),
      .res  (seed_res[c]),
      .wrap (seed_wrap_unused[c])
    );

    a_incr_range: assert property (@(posedge clk) disable iff (!reset_n)
      (adv_valid[c] && adv_ready) |-> (adv_incr[c*INCR_W +: INCR_W] <= INCR_W'(MAX_INCR)));
  end

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    ptr_d     = ptr_q;
    wrap_d    = '0;
    cfg_err_d = 1'b0;
    cfg_ready = (state_q == ST_RUN);
    adv_ready = (state_q == ST_RUN) && !cfg_valid;

    if (state_q == ST_CFG) state_d = ST_RUN;

    if (cfg_valid && cfg_ready && bcnt_legal(cfg_bcnt)) begin
      state_d = ST_CFG;
      bcnt_d  = cfg_bcnt;
      ptr_d   = '0;
    end else begin
      cfg_err_d = cfg_valid && cfg_ready;
      // A seed wins over a same-cycle advance, and that advance is dropped.
      for (int c = 0; c < NCHAN; c++) begin
        if (set_valid[c]) begin
          ptr_d[c] = seed_res[c];
        end else if (adv_valid[c] && adv_ready) begin
          ptr_d[c]  = adv_res[c];
          wrap_d[c] = adv_wrap[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      bcnt_q    <= BCNT_W'(RESET_BCNT);
      ptr_q     <= '0;
      wrap_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      ptr_q     <= ptr_d;
      wrap_q    <= wrap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bcnt    = bcnt_q;
  assign ptr     = ptr_q;
  assign wrap    = wrap_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_vu_vxu_bptr_tracker.sv
// Directed bench for vu_vxu_bptr_tracker, followed by a randomized run that is checked against a % model.
module tb_vu_vxu_bptr_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_bcnt;
  logic        cfg_err;
  logic [3:0]  bcnt;
  logic [3:0]  adv_valid;
  logic        adv_ready;
  logic [19:0] adv_incr;
  logic [3:0]  set_valid;
  logic [11:0] set_ptr;
  logic [11:0] ptr;
  logic [3:0]  wrap;

  int total = 0;
  int bad   = 0;

  int  m_ptr [4];
  int  m_bcnt;
  bit  m_run;
  int  m_wrap;
  int  m_err;

  vu_vxu_bptr_tracker dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_bcnt  (cfg_bcnt),
    .cfg_err   (cfg_err),
    .bcnt      (bcnt),
    .adv_valid (adv_valid),
    .adv_ready (adv_ready),
    .adv_incr  (adv_incr),
    .set_valid (set_valid),
    .set_ptr   (set_ptr),
    .ptr       (ptr),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cfg_valid = 1'b0;
    cfg_bcnt  = '0;
    adv_valid = '0;
    adv_incr  = '0;
    set_valid = '0;
    set_ptr   = '0;
  endtask

  task automatic adv(input int c, input int inc);
    adv_valid[c]       = 1'b1;
    adv_incr[c*5 +: 5] = 5'(inc);
  endtask

  task automatic seed(input int c, input int v);
    set_valid[c]      = 1'b1;
    set_ptr[c*3 +: 3] = 3'(v);
  endtask

  task automatic cfg(input int b);
    cfg_valid = 1'b1;
    cfg_bcnt  = 4'(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gp(input int c);
    return 32'(ptr[c*3 +: 3]);
  endfunction

  initial begin
    reset_n = 1'b0;
    clr();
    #12;
    chk("rst_ptr", 32'(ptr), 0);
    chk("rst_bcnt", 32'(bcnt), 8);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_adv_ready", 32'(adv_ready), 1);
    reset_n = 1'b1;
    tick();

    // Seed ptr0 to 7, then 7+10 = 17 gives 1 with a wrap at bcnt=8.
    seed(0, 7); tick(); clr();
    chk("seed0_7", gp(0), 7);
    chk("seed0_wrap", 32'(wrap), 0);
    adv(0, 10); tick(); clr();
    chk("adv10_ptr", gp(0), 1);
    chk("adv10_wrap", 32'(wrap), 1);
    adv(0, 0); tick(); clr();
    chk("adv0_ptr", gp(0), 1);
    chk("adv0_wrap", 32'(wrap), 0);

    // Set bcnt to 3. The CFG cycle stalls advances but still accepts a seed.
    cfg(3); #1;
    chk("cfg3_ready_pre", 32'(cfg_ready), 1);
    chk("cfg3_advrdy_pre", 32'(adv_ready), 0);
    tick(); clr();
    chk("cfg3_bcnt", 32'(bcnt), 3);
    chk("cfg3_ptr", 32'(ptr), 0);
    chk("cfg3_cfgrdy", 32'(cfg_ready), 0);
    seed(1, 2); tick(); clr();
    chk("seed1_in_cfg", gp(1), 2);
    chk("cfg3_back_run", 32'(cfg_ready), 1);
    adv(1, 17); tick(); clr();
    chk("adv17_mod3", gp(1), 1);
    chk("adv17_wrap", 32'(wrap), 4'b0010);

    // Seeds are reduced mod 3, a seed beats an advance on c2, and c1 gives 1+2=3 -> 0 with a wrap.
    seed(0, 3); seed(2, 7); seed(3, 5); adv(2, 5); adv(1, 2);
    tick(); clr();
    chk("mix_ptr", 32'(ptr), {3'd2, 3'd1, 3'd0, 3'd0});
    chk("mix_wrap", 32'(wrap), 4'b0010);

    // A config offer blocks the advances, and the same-cycle seed is ignored.
    cfg(5); adv(0, 3); adv(1, 3); adv(2, 3); adv(3, 3); seed(3, 4); #1;
    chk("cfg5_advrdy", 32'(adv_ready), 0);
    tick(); clr();
    chk("cfg5_bcnt", 32'(bcnt), 5);
    chk("cfg5_ptr", 32'(ptr), 0);
    chk("cfg5_wrap", 32'(wrap), 0);
    chk("cfg5_cfgrdy", 32'(cfg_ready), 0);
    adv(0, 3); seed(1, 4); #1;
    chk("cfgst_advrdy", 32'(adv_ready), 0);
    tick(); clr();
    chk("cfgst_adv_blk", gp(0), 0);
    chk("cfgst_seed", gp(1), 4);
    chk("cfg5_back_run", 32'(cfg_ready), 1);
    seed(0, 4); tick(); clr();
    adv(0, 17); tick(); clr();
    chk("adv17_mod5", gp(0), 1);
    chk("adv17_mod5_wrap", 32'(wrap), 1);

    // Illegal bank counts raise an error pulse and change nothing.
    cfg(2); adv(0, 1); #1;
    chk("bad2_advrdy", 32'(adv_ready), 0);
    tick(); clr();
    chk("bad2_err", 32'(cfg_err), 1);
    chk("bad2_bcnt", 32'(bcnt), 5);
    chk("bad2_ptr0", gp(0), 1);
    chk("bad2_cfgrdy", 32'(cfg_ready), 1);
    tick();
    chk("bad2_err_clr", 32'(cfg_err), 0);
    cfg(9); tick(); clr();
    chk("bad9_err", 32'(cfg_err), 1);
    chk("bad9_bcnt", 32'(bcnt), 5);
    chk("bad9_ptr1", gp(1), 4);

    cfg(8); tick(); clr();
    chk("cfg8_bcnt", 32'(bcnt), 8);
    chk("cfg8_ptr", 32'(ptr), 0);
    tick();

    // Randomized mix checked against a % model.
    m_bcnt = 8; m_run = 1'b1;
    for (int c = 0; c < 4; c++) m_ptr[c] = 0;
    for (int it = 0; it < 300; it++) begin
      bit exp_adv_rdy;
      int sum;
      clr();
      if ($urandom_range(7) == 0) cfg($urandom_range(15));
      for (int c = 0; c < 4; c++) begin
        adv_incr[c*5 +: 5] = 5'($urandom_range(17));
        adv_valid[c]       = ($urandom_range(1) == 1);
        set_valid[c]       = ($urandom_range(5) == 0);
        set_ptr[c*3 +: 3]  = 3'($urandom_range(7));
      end
      #1;
      exp_adv_rdy = m_run && !cfg_valid;
      chk("rnd_cfgrdy", 32'(cfg_ready), 32'(m_run));
      chk("rnd_advrdy", 32'(adv_ready), 32'(exp_adv_rdy));
      m_wrap = 0; m_err = 0;
      if (m_run && cfg_valid && cfg_bcnt >= 3 && cfg_bcnt <= 8) begin
        m_bcnt = int'(cfg_bcnt);
        for (int c = 0; c < 4; c++) m_ptr[c] = 0;
        m_run = 1'b0;
      end else begin
        if (m_run && cfg_valid) m_err = 1;
        for (int c = 0; c < 4; c++) begin
          if (set_valid[c]) begin
            m_ptr[c] = int'(set_ptr[c*3 +: 3]) % m_bcnt;
          end else if (adv_valid[c] && exp_adv_rdy) begin
            sum = m_ptr[c] + int'(adv_incr[c*5 +: 5]);
            m_ptr[c] = sum % m_bcnt;
            if (sum >= m_bcnt) m_wrap = m_wrap | (1 << c);
          end
        end
        m_run = 1'b1;
      end
      tick();
      chk("rnd_ptr", 32'(ptr), 32'({3'(m_ptr[3]), 3'(m_ptr[2]), 3'(m_ptr[1]), 3'(m_ptr[0])}));
      chk("rnd_wrap", 32'(wrap), 32'(m_wrap));
      chk("rnd_bcnt", 32'(bcnt), 32'(m_bcnt));
      chk("rnd_err", 32'(cfg_err), 32'(m_err));
    end
    clr();
    tick(); tick();

    // Reset asserted mid-traffic clears the state without a clock edge.
    cfg(4); tick(); clr();
    tick();
    seed(2, 3); tick(); clr();
    adv(2, 2); tick();
    chk("pre_rst_ptr2", gp(2), 1);
    chk("pre_rst_wrap", 32'(wrap), 4'b0100);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ptr", 32'(ptr), 0);
    chk("arst_bcnt", 32'(bcnt), 8);
    chk("arst_wrap", 32'(wrap), 0);
    clr();
    #3;
    reset_n = 1'b1;
    tick();
    chk("post_rst_ptr", 32'(ptr), 0);
    chk("post_rst_cfgrdy", 32'(cfg_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
